gcd_engine_mq: RTL and testbench
================================

Name: gcd_engine_mq

Overview:
- Parametrised, queued successor to the single-shot sequential GCD user block.
- Accepts tagged operand pairs over a valid/ready stream into an internal request FIFO, and computes one GCD at a time.
- Two algorithms, selected per request: subtractive Euclid and binary (Stein).
- Returns result, tag, iteration count and zero-operand flag over a valid/ready output stream. Sits in the user project area behind the LA/AXIS bridge.

Parameters:
- DATA_W, 32, operand/result width.
- TAG_W, 4, request tag width, returned unchanged with the result.
- FIFO_DEPTH, 4, request FIFO entries; power of two, >=2.
- CNT_W, 16, iteration counter width (saturating).

Ports:
- axis_clk  in  1  clock.
- axis_rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush: empties FIFO, aborts current job, drops out_valid.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid & in_ready.
- in_a  in  DATA_W  operand A.
- in_b  in  DATA_W  operand B.
- in_tag  in  TAG_W  request tag.
- in_mode  in  1  0 = subtractive Euclid, 1 = binary Stein; captured with the request.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid & out_ready.
- out_gcd  out  DATA_W  GCD result.
- out_tag  out  TAG_W  tag of the request.
- out_cycles  out  CNT_W  CALC cycles used, including the terminating cycle; saturates at all-ones.
- out_err  out  1  both operands were zero.
- busy  out  1  FSM not in IDLE.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  occupied FIFO entries.

Behaviour:
- Reset: all outputs 0 except in_ready=1; FIFO empty; FSM=IDLE. Reset is asynchronous and aborts any job mid-operation with no output.
- in_ready = (fifo_level < FIFO_DEPTH) & ~clear. There is no bypass: a full FIFO refuses a push even when a pop happens in the same cycle.
- FSM states:
  - IDLE: if FIFO non-empty, pop the head into registers a, b, tag, mode; clear k and cnt; go to CALC.
  - CALC: one step per cycle; cnt increments and saturates.
  - DONE: out_valid=1 with registered outputs held stable. On out_ready go to IDLE. The engine does not pop while in DONE.
- Subtractive step (mode 0), in priority order:
  - b==0 -> result a, go to DONE.
  - a<b -> swap a and b.
  - otherwise a = a-b.
- Binary step (mode 1), in priority order:
  - a==0 -> result b<<k, go to DONE.
  - b==0 -> result a<<k, go to DONE.
  - a and b both even -> a>>=1, b>>=1, k++.
  - a even -> a>>=1.
  - b even -> b>>=1.
  - a>=b -> a=a-b.
  - otherwise b=b-a.
  - k has width $clog2(DATA_W)+1.
- Arithmetic: unsigned, DATA_W bits; subtraction never underflows because of the compare ordering.
- Zero operands: gcd(x,0)=gcd(0,x)=x with out_err=0; gcd(0,0)=0 with out_err=1.
- Latency: a push at cycle t into an empty FIFO with the FSM in IDLE is popped at t+1. CALC starts at t+2. out_valid rises the cycle after the terminating CALC step.
- Throughput: back-to-back jobs resume IDLE->CALC with one IDLE cycle between them.
- clear has priority over all handshakes in that cycle:
  - next cycle: FIFO empty, FSM=IDLE, out_valid=0;
  - the push presented in that cycle is dropped (in_ready=0).
- Order: results return strictly in request order.

Test Plan:
- Push (a=12, b=18, mode 0, tag 3), out_ready=1 -> out_gcd=6, out_cycles=7, out_tag=3, out_err=0; out_valid rises 9 cycles after the push.
- Push (12, 18, mode 1, tag 5) -> out_gcd=6, out_cycles=6, out_tag=5.
- Push five requests back-to-back with out_ready=0, FIFO_DEPTH=4:
  - requests: (10312050, 29460792)=138; (1993627629, 1177417612)=7; (2097015289, 3812041926)=1; (1924134885, 3151131255)=135; (992211318, 512609597)=1; modes alternating; tags 0-4.
  - Required: in_ready drops once the FIFO holds 4 with the engine stalled in DONE. After out_ready=1, all five results appear in tag order with the listed values.
- Edge operands:
  - (0, 0) in both modes -> out_gcd=0, out_err=1, out_cycles=1.
  - (0, 25) mode 0 -> 25, err=0.
  - (2^DATA_W-1, 1) mode 1 -> 1.
  - Counter saturation: DATA_W=32, CNT_W=4, (1000000, 1) mode 0 -> out_cycles=15.
- Assert clear during CALC with 2 entries queued -> next cycle out_valid=0, fifo_level=0, busy=0. A subsequent push of (48, 36) returns 12.
- Drop axis_rst_n asynchronously mid-CALC -> all outputs return to reset values immediately. After release, a push of (7, 21) returns 7.

Source files
------------

// File: rtl/gcd_engine_mq.sv
`default_nettype none
// ============================================================================
// Module   : gcd_engine_mq
// Purpose  : Queued GCD engine. Tagged operand pairs arrive over a
//            valid/ready stream into a small request FIFO. One job at a time
//            is solved by either subtractive Euclid (mode 0) or binary Stein
//            (mode 1). The result returns over a valid/ready stream with its
//            tag, the number of CALC cycles used and a both-zero flag.
// Ports    : axis_clk, axis_rst_n (async, active-low), clear (sync flush)
//            in_valid/in_ready, in_a, in_b, in_tag, in_mode  - request stream
//            out_valid/out_ready, out_gcd, out_tag, out_cycles, out_err
//                                                           - result stream
//            busy (FSM not idle), fifo_level (occupied FIFO entries)
// Revision : 1.0 - initial release
// ============================================================================
module gcd_engine_mq #(
    parameter int DATA_W     = 32,
    parameter int TAG_W      = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                          axis_clk,
    input  logic                          axis_rst_n,
    input  logic                          clear,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_W-1:0]             in_a,
    input  logic [DATA_W-1:0]             in_b,
    input  logic [TAG_W-1:0]              in_tag,
    input  logic                          in_mode,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_W-1:0]             out_gcd,
    output logic [TAG_W-1:0]              out_tag,
    output logic [CNT_W-1:0]              out_cycles,
    output logic                          out_err,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_LW = c_AW + 1;
    localparam int c_KW = $clog2(DATA_W) + 1;
    localparam logic [c_LW-1:0] c_DEPTH = c_LW'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // ---------------- request FIFO ----------------
    logic [DATA_W-1:0] r_mem_a    [FIFO_DEPTH];
    logic [DATA_W-1:0] r_mem_b    [FIFO_DEPTH];
    logic [TAG_W-1:0]  r_mem_tag  [FIFO_DEPTH];
    logic              r_mem_mode [FIFO_DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_LW-1:0]   r_level;

    logic [1:0]        r_state;
    logic              w_push;
    logic              w_pop;

    // No bypass: a full FIFO refuses a push even if a pop happens this cycle.
    assign in_ready = (r_level < c_DEPTH) & ~clear;
    assign w_push   = in_valid & in_ready;
    assign w_pop    = (r_state == S_IDLE) & (r_level != '0) & ~clear;

    always_ff @(posedge axis_clk) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr]    <= in_a;
            r_mem_b[r_wr_ptr]    <= in_b;
            r_mem_tag[r_wr_ptr]  <= in_tag;
            r_mem_mode[r_wr_ptr] <= in_mode;
        end
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // ---------------- datapath ----------------
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [c_KW-1:0]   r_k;
    logic [CNT_W-1:0]  r_cnt;
    logic [TAG_W-1:0]  r_tag;
    logic              r_mode;
    logic              r_zero;

    logic [DATA_W-1:0] w_a_nxt;
    logic [DATA_W-1:0] w_b_nxt;
    logic [c_KW-1:0]   w_k_nxt;
    logic [DATA_W-1:0] w_result;
    logic              w_done;
    logic [CNT_W-1:0]  w_cnt_nxt;

    // Counter sticks at all-ones rather than wrapping.
    assign w_cnt_nxt = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

    always_comb begin
        w_a_nxt  = r_a;
        w_b_nxt  = r_b;
        w_k_nxt  = r_k;
        w_done   = 1'b0;
        w_result = r_a;
        if (!r_mode) begin
            if (r_b == '0) begin
                w_done   = 1'b1;
                w_result = r_a;
            end else if (r_a < r_b) begin
                w_a_nxt = r_b;
                w_b_nxt = r_a;
            end else begin
                w_a_nxt = r_a - r_b;
            end
        end else begin
            if (r_a == '0) begin
                w_done   = 1'b1;
                w_result = r_b << r_k;
            end else if (r_b == '0) begin
                w_done   = 1'b1;
                w_result = r_a << r_k;
            end else if (!r_a[0] && !r_b[0]) begin
                // Common factor of two: remembered in k, restored at the end.
                w_a_nxt = r_a >> 1;
                w_b_nxt = r_b >> 1;
                w_k_nxt = r_k + 1'b1;
            end else if (!r_a[0]) begin
                w_a_nxt = r_a >> 1;
            end else if (!r_b[0]) begin
                w_b_nxt = r_b >> 1;
            end else if (r_a >= r_b) begin
                w_a_nxt = r_a - r_b;
            end else begin
                w_b_nxt = r_b - r_a;
            end
        end
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            r_state    <= S_IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_k        <= '0;
            r_cnt      <= '0;
            r_tag      <= '0;
            r_mode     <= 1'b0;
            r_zero     <= 1'b0;
            out_gcd    <= '0;
            out_tag    <= '0;
            out_cycles <= '0;
            out_err    <= 1'b0;
        end else if (clear) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_a     <= r_mem_a[r_rd_ptr];
                        r_b     <= r_mem_b[r_rd_ptr];
                        r_tag   <= r_mem_tag[r_rd_ptr];
                        r_mode  <= r_mem_mode[r_rd_ptr];
                        r_zero  <= (r_mem_a[r_rd_ptr] == '0) && (r_mem_b[r_rd_ptr] == '0);
                        r_k     <= '0;
                        r_cnt   <= '0;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_a   <= w_a_nxt;
                    r_b   <= w_b_nxt;
                    r_k   <= w_k_nxt;
                    r_cnt <= w_cnt_nxt;
                    if (w_done) begin
                        out_gcd    <= w_result;
                        out_tag    <= r_tag;
                        out_cycles <= w_cnt_nxt;
                        out_err    <= r_zero;
                        r_state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out_valid  = (r_state == S_DONE);
    assign busy       = (r_state != S_IDLE);
    assign fifo_level = r_level;

endmodule
`default_nettype wire

// File: tb/tb_gcd_engine_mq.sv
`default_nettype none
// ============================================================================
// Module   : tb_gcd_engine_mq
// Purpose  : Scoreboard bench for gcd_engine_mq. Requests are pushed with
//            their expected response; a monitor pops and compares on every
//            accepted result. A second instance with a 4-bit counter shares
//            the stimulus to exercise counter saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gcd_engine_mq;

    localparam int DW    = 32;
    localparam int TW    = 4;
    localparam int DEPTH = 4;
    localparam int CW    = 16;
    localparam int CW2   = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_a = '0;
    logic [DW-1:0] in_b = '0;
    logic [TW-1:0] in_tag = '0;
    logic          in_mode = 1'b0;
    logic          out_ready = 1'b0;

    logic          in_ready, out_valid, out_err, busy;
    logic [DW-1:0] out_gcd;
    logic [TW-1:0] out_tag;
    logic [CW-1:0] out_cycles;
    logic [LW-1:0] fifo_level;

    logic           in_ready2, out_valid2, out_err2, busy2;
    logic [DW-1:0]  out_gcd2;
    logic [TW-1:0]  out_tag2;
    logic [CW2-1:0] out_cycles2;
    logic [LW-1:0]  fifo_level2;

    gcd_engine_mq #(.DATA_W(DW), .TAG_W(TW), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) u_dut (
        .axis_clk(clk), .axis_rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_tag(in_tag), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_gcd(out_gcd),
        .out_tag(out_tag), .out_cycles(out_cycles), .out_err(out_err),
        .busy(busy), .fifo_level(fifo_level)
    );

    gcd_engine_mq #(.DATA_W(DW), .TAG_W(TW), .FIFO_DEPTH(DEPTH), .CNT_W(CW2)) u_dut_sat (
        .axis_clk(clk), .axis_rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready2), .in_a(in_a), .in_b(in_b),
        .in_tag(in_tag), .in_mode(in_mode),
        .out_valid(out_valid2), .out_ready(out_ready), .out_gcd(out_gcd2),
        .out_tag(out_tag2), .out_cycles(out_cycles2), .out_err(out_err2),
        .busy(busy2), .fifo_level(fifo_level2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] g;
        logic [TW-1:0] tag;
        longint        cyc;
        logic          err;
    } exp_t;

    exp_t   sb[$];
    int     vectors = 0;
    int     errors  = 0;
    longint cyc_cnt = 0;
    longint last_push_cyc = 0;
    logic   rand_ready = 1'b0;
    logic   fixed_ready = 1'b0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference gcd by remainder Euclid, independent of either step rule.
    function automatic logic [DW-1:0] ref_gcd(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Number of algorithm steps, terminating step included.
    function automatic longint ref_cycles(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic mode);
        longint n = 1;
        logic [DW-1:0] t;
        if (!mode) begin
            while (b != 0) begin
                if (a < b) begin t = a; a = b; b = t; end
                else a = a - b;
                n++;
            end
        end else begin
            while (a != 0 && b != 0) begin
                if (a % 2 == 0 && b % 2 == 0) begin a = a / 2; b = b / 2; end
                else if (a % 2 == 0) a = a / 2;
                else if (b % 2 == 0) b = b / 2;
                else if (a >= b) a = a - b;
                else b = b - a;
                n++;
            end
        end
        return n;
    endfunction

    task automatic push(input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [TW-1:0] tag, input logic mode);
        exp_t e;
        int   n = 0;
        bit   ok = 1'b1;
        in_a = a; in_b = b; in_tag = tag; in_mode = mode; in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 30000) begin
                ok = 1'b0;
                vectors++; errors++;
                $display("FAIL push_timeout: got no accept expected accept (tag %0d)", tag);
                break;
            end
        end
        if (ok) begin
            e.g = ref_gcd(a, b);
            e.tag = tag;
            e.cyc = ref_cycles(a, b, mode);
            e.err = (a == 0) && (b == 0);
            sb.push_back(e);
            last_push_cyc = cyc_cnt;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((sb.size() != 0 || busy || fifo_level != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            vectors++; errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_in_ready"},   in_ready, 1);
        chk({tag, "_out_valid"},  out_valid, 0);
        chk({tag, "_busy"},       busy, 0);
        chk({tag, "_fifo_level"}, fifo_level, 0);
        chk({tag, "_out_gcd"},    out_gcd, 0);
        chk({tag, "_out_tag"},    out_tag, 0);
        chk({tag, "_out_cycles"}, out_cycles, 0);
        chk({tag, "_out_err"},    out_err, 0);
    endtask

    // out_ready driver: fixed level or random per cycle.
    initial forever begin
        @(posedge clk); #1;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : fixed_ready;
    end

    // Monitor: compares every result that is consumed.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                vectors++; errors++;
                $display("FAIL unexpected_result: got tag %0d gcd %0d expected none", out_tag, out_gcd);
            end else begin
                e = sb.pop_front();
                chk("out_gcd",    out_gcd, e.g);
                chk("out_tag",    out_tag, e.tag);
                chk("out_err",    out_err, e.err);
                chk("out_cycles", out_cycles, (e.cyc > 65535) ? 65535 : e.cyc);
                chk("sat_valid",  out_valid2, 1);
                chk("sat_gcd",    out_gcd2, e.g);
                chk("sat_cycles", out_cycles2, (e.cyc > 15) ? 15 : e.cyc);
            end
        end
    end

    initial begin
        int n;
        logic [DW-1:0] ra, rb;
        logic          rm;

        // Reset state
        #2;
        chk_reset_values("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        fixed_ready = 1'b1;
        @(posedge clk); #1;

        // Basic subtractive job with latency check
        push(32'd12, 32'd18, 4'd3, 1'b0);
        n = 0;
        while (!out_valid && n < 100) begin @(negedge clk); n++; end
        chk("latency_push_to_valid", cyc_cnt - last_push_cyc, 9);
        drain(200);

        // Basic binary job
        push(32'd12, 32'd18, 4'd5, 1'b1);
        drain(200);

        // Five back-to-back with the output stalled
        fixed_ready = 1'b0;
        @(posedge clk); #1;
        push(32'd10312050,   32'd29460792,   4'd0, 1'b0);
        push(32'd1993627629, 32'd1177417612, 4'd1, 1'b1);
        push(32'd2097015289, 32'd3812041926, 4'd2, 1'b0);
        push(32'd1924134885, 32'd3151131255, 4'd3, 1'b1);
        push(32'd992211318,  32'd512609597,  4'd4, 1'b0);
        in_valid = 1'b1;
        repeat (2000) @(negedge clk);
        chk("full_in_ready",   in_ready, 0);
        chk("full_fifo_level", fifo_level, 4);
        chk("full_out_valid",  out_valid, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        fixed_ready = 1'b1;
        drain(20000);

        // Edge operands; (1000,1) mode 0 overflows the 4-bit counter
        push(32'd0, 32'd0, 4'd6, 1'b0);
        push(32'd0, 32'd0, 4'd7, 1'b1);
        push(32'd0, 32'd25, 4'd8, 1'b0);
        push(32'hFFFF_FFFF, 32'd1, 4'd9, 1'b1);
        push(32'd1000, 32'd1, 4'd10, 1'b0);
        drain(5000);

        // Synchronous clear mid-CALC with two entries queued
        push(32'd1000, 32'd1, 4'd11, 1'b0);
        push(32'd48, 32'd36, 4'd12, 1'b0);
        push(32'd100, 32'd75, 4'd13, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("pre_clear_fifo_level", fifo_level, 2);
        clear = 1'b1;
        in_valid = 1'b1;
        in_a = 32'd5; in_b = 32'd5; in_tag = 4'd15;
        @(negedge clk);
        chk("clear_in_ready", in_ready, 0);
        @(posedge clk); #1;
        clear = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        chk("post_clear_out_valid",  out_valid, 0);
        chk("post_clear_fifo_level", fifo_level, 0);
        chk("post_clear_busy",       busy, 0);
        push(32'd48, 32'd36, 4'd1, 1'b0);
        drain(500);

        // Asynchronous reset mid-CALC
        push(32'd1000, 32'd1, 4'd2, 1'b1);
        push(32'd1000, 32'd1, 4'd3, 1'b0);
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        sb.delete();
        #1;
        chk_reset_values("async_reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        push(32'd7, 32'd21, 4'd4, 1'b0);
        drain(500);

        // Randomised traffic with random back-pressure
        rand_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            rm = 1'($urandom_range(0, 1));
            do begin
                case ($urandom_range(0, 3))
                    0: begin ra = $urandom; rb = $urandom; end
                    1: begin
                        n  = $urandom_range(1, 5000);
                        ra = DW'(n) * DW'($urandom_range(1, 50000));
                        rb = DW'(n) * DW'($urandom_range(1, 50000));
                    end
                    2: begin
                        n  = $urandom_range(0, 12);
                        ra = DW'($urandom_range(0, 65535)) << n;
                        rb = DW'($urandom_range(0, 65535)) << n;
                    end
                    default: begin ra = DW'($urandom_range(0, 40)); rb = DW'($urandom_range(0, 40)); end
                endcase
            end while (ref_cycles(ra, rb, rm) > 4000);
            push(ra, rb, TW'(i), rm);
        end
        drain(60000);
        rand_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
